y_demux1to4: RTL
================

# y_demux1to4

Registered 1-to-4 demultiplexer: the inverse of the `yMux4to1` datapath selector. It accepts one SIZE-bit word per handshake together with a 2-bit channel select, and steers the word into one of four independent one-entry output holding registers. Each output has its own valid/ready handshake. The block sits between a single producer and four consumer lanes. Per-channel delivery counters support lab self-checking.

## Interface
Parameters:
- SIZE, 32, data width of input and each output lane
- CNTW, 8, width of each per-channel delivery counter

Ports:
- clk  input  1  rising-edge clock; all state changes on this edge
- reset  input  1  synchronous, active-high; sampled on rising clk
- in_valid  input  1  producer offers a word
- in_ready  output  1  block can accept the word for the currently selected channel
- in_data  input  SIZE  word to route
- in_sel  input  2  target channel: 00→lane 0, 01→lane 1, 10→lane 2, 11→lane 3
- out_valid  output  4  bit k: lane k holding register is full
- out_ready  input  4  bit k: consumer k takes the word this cycle
- out_data0..out_data3  output  SIZE each  lane holding registers
- out_count0..out_count3  output  CNTW each  words delivered to consumer k, modulo 2^CNTW

## Operation
- Per lane k: holding register `data_k`, flag `full_k` (= out_valid[k]), counter `count_k`.
- `in_ready` is combinational: `!full[in_sel] || out_ready[in_sel]`. It depends only on the selected lane. Other lanes never stall the input.
- Accept: `acc = in_valid && in_ready`. On accept, `data[in_sel] <= in_data` and `full[in_sel] <= 1`.
- Drain lane k: `drn_k = full_k && out_ready[k]`. On drain without a same-lane accept, `full_k <= 0`. Every drain increments `count_k`, which wraps from 2^CNTW-1 to 0.
- Simultaneous drain and accept on the same lane: the old word is delivered and counted, the new word is loaded, and `full_k` stays 1. This gives full throughput of one word per cycle per lane.
- Drains on different lanes in the same cycle are independent. Up to 4 drains and 1 accept can occur per cycle.
- `out_data_k` holds its value until the next load. It is not cleared on drain, and its contents are don't-care while `out_valid[k]` = 0.
- `out_ready[k]` while `full_k` = 0 has no effect.
- `in_data` and `in_sel` while `in_valid` = 0 have no effect on state.
- Producer rule: `in_data` and `in_sel` are held stable while `in_valid && !in_ready`. The block does not depend on this for correctness, because it evaluates the current `in_sel` every cycle.
- Reset, including mid-operation: all `full_k` = 0, all `data_k` = 0, all `count_k` = 0. Held words are discarded without being counted. A reset cycle accepts nothing and drains nothing.

## Timing
- Reset values:
  - out_valid = 4'b0000
  - out_data0..3 = 0
  - out_count0..3 = 0
  - in_ready = 1 for any in_sel, once reset is deasserted
- Latency:
  - A word accepted at edge N is visible on out_data/out_valid after edge N: 1 cycle.
  - A count increment caused by a drain at edge N is visible after edge N.
- Path depth: in_ready has a combinational path from in_sel and out_ready. There is no combinational path from in_data to any output.
- Each lane sustains 1 word/cycle when its consumer holds out_ready = 1.

## Test plan
- Reset then route: assert reset for 2 cycles and check all outputs are zero. Send in_data=32'hDEADBEEF with in_sel=2'b10 and all out_ready=0. Next cycle: out_valid=4'b0100, out_data2=32'hDEADBEEF, in_ready=0 for sel 10 and in_ready=1 for sel 00.
- Backpressure and stall: with lane 2 full and out_ready=0, hold in_valid=1, in_sel=10, in_data=32'h1. Check in_ready=0 and out_data2 unchanged for 3 cycles. Raise out_ready[2]: in the same cycle in_ready=1; after the edge out_data2=32'h1, out_valid[2]=1, out_count2=1.
- Streaming: hold out_ready=4'b1111 and send 10 $random words with $random in_sel. Each word appears on the selected lane exactly one cycle later, and the count totals across lanes sum to 10 (the final words are drained in the following cycle).
- Parallel drain: fill all four lanes with 32'h0, 32'h1, 32'h2, 32'h3. Assert out_ready=4'b1111 for one cycle with in_valid=0. Then out_valid=0000 and each count = 1.
- Wrap: with CNTW=8, perform 256 drains on lane 1; out_count1 returns to 0. The 257th drain gives out_count1=1.
- Reset mid-operation: with lanes 0 and 3 full and out_count0=5, assert reset for one cycle with out_ready=4'b1111 and in_valid=1. Afterwards out_valid=0000 and all counts are 0. The word offered during reset is not captured.

Source files
------------

// File: rtl/y_demux1to4_if.sv
// y_demux1to4_if: handshake bundle for the registered 1-to-4 demultiplexer.
//   in_valid/in_ready/in_data/in_sel : single producer side
//   out_valid/out_ready              : per-lane consumer handshakes (bit k = lane k)
//   out_data0..3                     : lane holding registers
//   out_count0..3                    : per-lane delivered-word counters (wrap)
// slave modport is the demux view; master modport is the producer/consumer view.
interface y_demux1to4_if #(
    parameter int SIZE = 32,
    parameter int CNTW = 8
);
    logic            in_valid;
    logic            in_ready;
    logic [SIZE-1:0] in_data;
    logic [1:0]      in_sel;
    logic [3:0]      out_valid;
    logic [3:0]      out_ready;
    logic [SIZE-1:0] out_data0;
    logic [SIZE-1:0] out_data1;
    logic [SIZE-1:0] out_data2;
    logic [SIZE-1:0] out_data3;
    logic [CNTW-1:0] out_count0;
    logic [CNTW-1:0] out_count1;
    logic [CNTW-1:0] out_count2;
    logic [CNTW-1:0] out_count3;

    modport slave (
        input  in_valid, in_data, in_sel, out_ready,
        output in_ready, out_valid,
        output out_data0, out_data1, out_data2, out_data3,
        output out_count0, out_count1, out_count2, out_count3
    );

    modport master (
        output in_valid, in_data, in_sel, out_ready,
        input  in_ready, out_valid,
        input  out_data0, out_data1, out_data2, out_data3,
        input  out_count0, out_count1, out_count2, out_count3
    );
endinterface

// File: rtl/y_demux1to4.sv
// y_demux1to4: registered 1-to-4 demultiplexer with one-entry holding
// register per lane and independent valid/ready handshakes.
//   clk   : rising-edge clock
//   reset : synchronous, active-high; clears all lanes and counters
//   bus   : y_demux1to4_if.slave (producer handshake, 4 consumer lanes,
//           lane data registers and per-lane delivery counters)
module y_demux1to4 #(
    parameter int SIZE = 32,
    parameter int CNTW = 8
) (
    input  logic          clk,
    input  logic          reset,
    y_demux1to4_if.slave  bus
);
    logic [SIZE-1:0] data_q [4];
    logic [CNTW-1:0] cnt_q  [4];
    logic [3:0]      full_q;
    logic [3:0]      load;
    logic [3:0]      drain;
    logic            acc;

    // Readiness looks only at the selected lane; a full lane that drains
    // this cycle can take a new word at the same time.
    assign bus.in_ready = !full_q[bus.in_sel] || bus.out_ready[bus.in_sel];

    always_comb begin
        acc   = bus.in_valid && bus.in_ready;
        load  = '0;
        if (acc) begin
            load = 4'b0001 << bus.in_sel;
        end
        drain = full_q & bus.out_ready;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            full_q <= '0;
            for (int unsigned k = 0; k < 4; k++) begin
                data_q[k] <= '0;
                cnt_q[k]  <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < 4; k++) begin
                if (load[k]) begin
                    data_q[k] <= bus.in_data;
                    full_q[k] <= 1'b1;
                end else if (drain[k]) begin
                    full_q[k] <= 1'b0;
                end
                if (drain[k]) begin
                    cnt_q[k] <= cnt_q[k] + CNTW'(1);
                end
            end
        end
    end

    assign bus.out_valid  = full_q;
    assign bus.out_data0  = data_q[0];
    assign bus.out_data1  = data_q[1];
    assign bus.out_data2  = data_q[2];
    assign bus.out_data3  = data_q[3];
    assign bus.out_count0 = cnt_q[0];
    assign bus.out_count1 = cnt_q[1];
    assign bus.out_count2 = cnt_q[2];
    assign bus.out_count3 = cnt_q[3];
endmodule
